// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the FIFO dual-port memory.
// NREQ producers compete for the single memory write port. A grant is held
// for one packet: it ends on the producer's last beat, or after MAXBURST beats.
// Priority then rotates to the producer after the one just served.
// Memory write enable and write-pointer increment come from the same
// combinational term, so they cannot disagree. Neither fires while wfull is high.
module fifo_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 8
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_last,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    output logic                      wclken,
    output logic                      winc,
    output logic [DSIZE-1:0]          wdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [GW-1:0]     rr_ptr;
    logic [CW-1:0]     beat_cnt;

    logic [GW-1:0]     winner;
    logic              any_valid;
    int                idx;
    logic [GW-1:0]     idx_v;

    logic [DSIZE-1:0]  gnt_data;
    logic              gnt_valid;
    logic              gnt_last;
    logic              locked;
    logic              xfer;
    logic              pkt_end;
    logic [GW-1:0]     next_ptr;

    // Round-robin search. Offsets are scanned from highest to lowest, so the
    // surviving winner is the first valid requester at or above rr_ptr.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = GW'(idx);
            if (req_valid[idx_v]) begin
                winner    = idx_v;
                any_valid = 1'b1;
            end
        end
    end

    // Select the granted producer's beat. Constant slice indices keep this a plain mux.
    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == GW'(i)) begin
                gnt_data  = req_data[i*DSIZE +: DSIZE];
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
            end
        end
    end

    // Transfer qualification and memory-side outputs, same cycle as wfull.
    always_comb begin
        locked   = (state == LOCKED);
        xfer     = locked & gnt_valid & ~wfull;
        pkt_end  = gnt_last | (beat_cnt == CW'(MAXBURST - 1));
        next_ptr = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        wclken   = xfer;
        winc     = xfer;
        wdata    = locked ? gnt_data : '0;
        busy     = locked;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = locked & ~wfull & (grant_id == GW'(i));
        end
    end

    // Grant FSM. IDLE picks a winner (one bubble per packet). LOCKED counts
    // accepted beats and releases on last beat or at the burst limit.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (pkt_end) begin
                            state    <= IDLE;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Producers must hold data and last steady while a beat waits for ready.
    for (genvar g = 0; g < NREQ; g++) begin : g_hold
        a_stable: assert property (@(posedge wclk) disable iff (!wrst_n)
            (req_valid[g] && !req_ready[g]) ##1 req_valid[g]
                |-> ($stable(req_data[g*DSIZE +: DSIZE]) && $stable(req_last[g])));
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NREQ=4, DSIZE=8, MAXBURST=8).
// Each producer is a small beat list that the bench presents one beat at a time.
// A beat advances only after it has been accepted.
// Every memory write is logged and compared against hand-written expected sequences.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        wclken;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_write_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(8)) dut (
        .wclk      (clk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .wclken    (wclken),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // producer beat lists: {last, data}
    logic [8:0]  pmem [4][16];
    int          phead [4];
    int          pcnt  [4];
    logic [3:0]  hold;

    // per-cycle snapshot taken at the falling edge
    logic        s_wclken, s_winc, s_busy;
    logic [7:0]  s_wdata;
    logic [1:0]  s_gid;
    logic [3:0]  s_ready;

    logic [1:0]  log_id  [128];
    logic [7:0]  log_dat [128];
    int          nlog;
    int          wr_cnt;
    int          inc_cnt;
    int          base;

    int          vec_cnt;
    int          miscmp_cnt;

    logic [7:0]  exp2_d  [3]  = '{8'hA1, 8'hA2, 8'hA3};
    logic [1:0]  exp3_id [8]  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0]  exp3_d  [8]  = '{8'h60, 8'h70, 8'h40, 8'h50, 8'h61, 8'h71, 8'h41, 8'h51};
    logic [1:0]  exp4_id [13] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [7:0]  exp4_d  [13] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
                                  8'hC3, 8'h88, 8'h89, 8'h8A, 8'h8B};
    logic [7:0]  exp5_d  [4]  = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    logic [1:0]  exp6_id [6]  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [7:0]  exp6_d  [6]  = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hF2, 8'hF3};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l);
        pmem[p][pcnt[p]] = {l, d};
        pcnt[p]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (phead[i] < pcnt[i] && !hold[i]) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = pmem[i][phead[i]][8];
                req_data[i*8 +: 8]  = pmem[i][phead[i]][7:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            phead[i] = 0;
            pcnt[i]  = 0;
        end
        hold = 4'b0000;
        drive();
    endtask

    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        s_wclken = wclken;
        s_winc   = winc;
        s_busy   = busy;
        s_wdata  = wdata;
        s_gid    = grant_id;
        s_ready  = req_ready;
        acc      = req_valid & req_ready;
        if (wclken) begin
            log_id[nlog]  = grant_id;
            log_dat[nlog] = wdata;
            nlog++;
        end
        wr_cnt  += int'(wclken);
        inc_cnt += int'(winc);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) phead[i]++;
        end
        drive();
    endtask

    task automatic check_wr(input string tag, input int n, input logic [1:0] id, input logic [7:0] d);
        check_eq($sformatf("%s_w%0d_id", tag, n), 32'(log_id[n]), 32'(id));
        check_eq($sformatf("%s_w%0d_data", tag, n), 32'(log_dat[n]), 32'(d));
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        nlog       = 0;
        wr_cnt     = 0;
        inc_cnt    = 0;
        wrst_n     = 1'b0;
        wfull      = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        for (int i = 0; i < 128; i++) begin
            log_id[i]  = '0;
            log_dat[i] = '0;
        end
        flush();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wclken", 32'(wclken), 32'd0);
        check_eq("rst_winc",   32'(winc),   32'd0);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_gid",    32'(grant_id), 32'd0);
        check_eq("rst_ready",  32'(req_ready), 32'd0);
        check_eq("rst_wdata",  32'(wdata),  32'd0);
        @(posedge clk);
        #1;
        wrst_n = 1'b1;

        // single producer 1, three-beat packet
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        drive();
        tick();
        check_eq("t2_bubble_wclken", 32'(s_wclken), 32'd0);
        check_eq("t2_bubble_busy",   32'(s_busy),   32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("t2_b%0d_wclken", k), 32'(s_wclken), 32'd1);
            check_eq($sformatf("t2_b%0d_winc", k),   32'(s_winc),   32'd1);
            check_eq($sformatf("t2_b%0d_wdata", k),  32'(s_wdata),  32'(exp2_d[k]));
            check_eq($sformatf("t2_b%0d_gid", k),    32'(s_gid),    32'd1);
            check_eq($sformatf("t2_b%0d_ready", k),  32'(s_ready),  32'h2);
        end
        tick();
        check_eq("t2_end_busy",   32'(s_busy),   32'd0);
        check_eq("t2_end_wclken", 32'(s_wclken), 32'd0);

        // all four producers with one-beat packets; priority starts at 2
        base = nlog;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                push(i, 8'(8'h40 + 16 * i + k), 1'b1);
            end
        end
        drive();
        for (int t = 0; t < 16; t++) begin
            tick();
            check_eq($sformatf("t3_c%0d_wclken", t), 32'(s_wclken), 32'(t % 2));
        end
        check_eq("t3_count", 32'(nlog - base), 32'd8);
        for (int n = 0; n < 8; n++) check_wr("t3", base + n, exp3_id[n], exp3_d[n]);

        // producer 2 twelve-beat packet vs. waiting producer 3: burst limit at 8
        base = nlog;
        for (int k = 0; k < 12; k++) push(2, 8'(8'h80 + k), k == 11);
        push(3, 8'hC3, 1'b1);
        drive();
        repeat (17) tick();
        check_eq("t4_count", 32'(nlog - base), 32'd13);
        check_eq("t4_end_busy", 32'(s_busy), 32'd0);
        for (int n = 0; n < 13; n++) check_wr("t4", base + n, exp4_id[n], exp4_d[n]);

        // FIFO full for five cycles after beat 2 of 4
        base = nlog;
        for (int k = 0; k < 4; k++) push(0, 8'(8'hD0 + k), k == 3);
        drive();
        repeat (3) tick();
        wfull = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            check_eq($sformatf("t5_full%0d_wclken", t), 32'(s_wclken), 32'd0);
            check_eq($sformatf("t5_full%0d_winc", t),   32'(s_winc),   32'd0);
            check_eq($sformatf("t5_full%0d_ready", t),  32'(s_ready),  32'd0);
            check_eq($sformatf("t5_full%0d_busy", t),   32'(s_busy),   32'd1);
        end
        wfull = 1'b0;
        tick();
        check_eq("t5_resume_wclken", 32'(s_wclken), 32'd1);
        repeat (2) tick();
        check_eq("t5_count", 32'(nlog - base), 32'd4);
        for (int n = 0; n < 4; n++) check_wr("t5", base + n, 2'd0, exp5_d[n]);

        // granted producer 1 pauses for three cycles while 2 and 3 wait
        base = nlog;
        for (int k = 0; k < 4; k++) push(1, 8'(8'hE0 + k), k == 3);
        push(2, 8'hF2, 1'b1);
        push(3, 8'hF3, 1'b1);
        drive();
        repeat (3) tick();
        hold[1] = 1'b1;
        drive();
        for (int t = 0; t < 3; t++) begin
            tick();
            check_eq($sformatf("t6_gap%0d_wclken", t), 32'(s_wclken), 32'd0);
            check_eq($sformatf("t6_gap%0d_gid", t),    32'(s_gid),    32'd1);
            check_eq($sformatf("t6_gap%0d_busy", t),   32'(s_busy),   32'd1);
        end
        hold[1] = 1'b0;
        drive();
        repeat (7) tick();
        check_eq("t6_count", 32'(nlog - base), 32'd6);
        for (int n = 0; n < 6; n++) check_wr("t6", base + n, exp6_id[n], exp6_d[n]);

        // reset in the middle of a packet; rotation pointer returns to 0
        push(1, 8'h11, 1'b1);
        drive();
        repeat (3) tick();
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h23, 1'b1);
        drive();
        repeat (2) tick();
        #2;
        wrst_n = 1'b0;
        #1;
        check_eq("t1_mid_wclken", 32'(wclken),    32'd0);
        check_eq("t1_mid_winc",   32'(winc),      32'd0);
        check_eq("t1_mid_busy",   32'(busy),      32'd0);
        check_eq("t1_mid_gid",    32'(grant_id),  32'd0);
        check_eq("t1_mid_ready",  32'(req_ready), 32'd0);
        check_eq("t1_mid_wdata",  32'(wdata),     32'd0);
        flush();
        @(posedge clk);
        #1;
        wrst_n = 1'b1;
        base = nlog;
        push(3, 8'h33, 1'b1);
        push(0, 8'h30, 1'b1);
        drive();
        repeat (4) tick();
        check_eq("t1_post_count", 32'(nlog - base), 32'd2);
        check_wr("t1_post", base,     2'd0, 8'h30);
        check_wr("t1_post", base + 1, 2'd3, 8'h33);

        // writes and pointer increments over the whole run
        check_eq("total_wclken", 32'(wr_cnt),  32'd38);
        check_eq("total_winc",   32'(inc_cnt), 32'd38);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
